// File: rtl/regshifter_pkg.sv
// regshifter_pkg: state and shift-select encodings shared by the sequencer, the
// SC_RegSHIFTER integration and the testbench.
package regshifter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4,
        ABORT = 3'd5
    } state_t;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_LEFT  = 2'b01;
    localparam logic [1:0] SEL_RIGHT = 2'b10;

    function automatic logic [1:0] sel_for_dir(input logic dir);
        return dir ? SEL_RIGHT : SEL_LEFT;
    endfunction

endpackage

// File: rtl/regshifter_seq_counter.sv
// regshifter_seq_counter: loadable down-counter holding the remaining shift count,
// with zero/one flags; saturates at zero so an aborted or stalled run cannot wrap.
module regshifter_seq_counter #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 SC_RegSHIFTER_CLOCK_50,
    input  logic                 SC_RegSHIFTER_RESET_InHigh,
    input  logic                 i_load,
    input  logic [CNT_WIDTH-1:0] i_load_val,
    input  logic                 i_en,
    output logic                 o_zero,
    output logic                 o_one
);

    localparam logic [CNT_WIDTH-1:0] ONE = 1;

    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge SC_RegSHIFTER_CLOCK_50 or posedge SC_RegSHIFTER_RESET_InHigh) begin
        if (SC_RegSHIFTER_RESET_InHigh)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_en && r_count != '0)
            r_count <= r_count - ONE;
    end

    assign o_zero = r_count == '0;
    assign o_one  = r_count == ONE;

endmodule

// File: rtl/regshifter_sequencer.sv
// regshifter_sequencer: sequences one SC_RegSHIFTER through clear / load / N shifts.
// Optional REGSHIFTER_SEQ_STEP_EN adds step_in to gate each shift individually.
module regshifter_sequencer
    import regshifter_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 SC_RegSHIFTER_CLOCK_50,
    input  logic                 SC_RegSHIFTER_RESET_InHigh,
    input  logic                 req_in,
    input  logic                 clear_req_in,
    input  logic                 dir_in,
    input  logic [CNT_WIDTH-1:0] count_in,
    input  logic [DATAWIDTH-1:0] data_in,
    input  logic                 abort_in,
`ifdef REGSHIFTER_SEQ_STEP_EN
    input  logic                 step_in,
`endif
    output logic                 shifter_clear_InLow,
    output logic                 shifter_load_InLow,
    output logic [1:0]           shifter_shiftselection_InLow,
    output logic [DATAWIDTH-1:0] shifter_data_OutBUS,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 aborted_out
);

    state_t               r_state, w_next;
    logic                 r_dir;
    logic [DATAWIDTH-1:0] r_data;
    logic                 w_step, w_capture, w_zero, w_one;

`ifdef REGSHIFTER_SEQ_STEP_EN
    assign w_step = step_in;
`else
    assign w_step = 1'b1;
`endif

    assign w_capture = r_state == IDLE && !clear_req_in && req_in;

    regshifter_seq_counter #(.CNT_WIDTH(CNT_WIDTH)) u_counter (
        .SC_RegSHIFTER_CLOCK_50    (SC_RegSHIFTER_CLOCK_50),
        .SC_RegSHIFTER_RESET_InHigh(SC_RegSHIFTER_RESET_InHigh),
        .i_load                    (w_capture),
        .i_load_val                (count_in),
        .i_en                      (r_state == SHIFT && w_step),
        .o_zero                    (w_zero),
        .o_one                     (w_one)
    );

    always_ff @(posedge SC_RegSHIFTER_CLOCK_50 or posedge SC_RegSHIFTER_RESET_InHigh) begin
        if (SC_RegSHIFTER_RESET_InHigh) begin
            r_state <= IDLE;
            r_dir   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_dir  <= dir_in;
                r_data <= data_in;
            end
        end
    end

    // The shift of the cycle that samples abort still goes out; ABORT itself holds.
    always_comb begin
        w_next                       = r_state;
        shifter_clear_InLow          = r_state != CLEAR;
        shifter_load_InLow           = r_state != LOAD;
        shifter_shiftselection_InLow = (r_state == SHIFT && w_step) ? sel_for_dir(r_dir) : SEL_HOLD;
        shifter_data_OutBUS          = r_data;
        busy_out                     = r_state != IDLE;
        done_out                     = r_state == DONE;
        aborted_out                  = r_state == ABORT;
        unique case (r_state)
            IDLE:    w_next = clear_req_in ? CLEAR : (req_in ? LOAD : IDLE);
            CLEAR:   w_next = DONE;
            LOAD:    w_next = w_zero ? DONE : SHIFT;
            SHIFT:   w_next = abort_in ? ABORT : ((w_step && w_one) ? DONE : SHIFT);
            DONE:    w_next = IDLE;
            ABORT:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: doc/regshifter_sequencer.md
Name: regshifter_sequencer

Overview:
- Control FSM that sequences one SC_RegSHIFTER datapath instance: clear, parallel load, then N single-bit shifts in a chosen direction.
- Drives the shifter's active-low clear, load and 2-bit shift-select controls, plus its data input bus.
- Exposes a single-command req/busy/done interface to the upstream controller (e.g. the Fibonacci/uDataPath top) so that block no longer hand-toggles shifter controls.

Parameters:
DATAWIDTH, 8, width of the data bus forwarded to the shifter; must equal the shifter's RegSHIFTER_DATAWIDTH.
CNT_WIDTH, 4, width of the shift-count field; max shifts per command = 2^CNT_WIDTH-1.

Ports:
SC_RegSHIFTER_CLOCK_50  in  1  system clock; all state changes on its rising edge.
SC_RegSHIFTER_RESET_InHigh  in  1  asynchronous, active-high reset.
req_in  in  1  command request; sampled only in IDLE.
clear_req_in  in  1  clear-only command; sampled only in IDLE.
dir_in  in  1  0 = shift left, 1 = shift right.
count_in  in  CNT_WIDTH  number of shifts to perform.
data_in  in  DATAWIDTH  value to load into the shifter.
abort_in  in  1  terminates an in-progress SHIFT sequence.
shifter_clear_InLow  out  1  to shifter clear input; active low.
shifter_load_InLow  out  1  to shifter load input; active low.
shifter_shiftselection_InLow  out  2  to shifter: 01 = left, 10 = right, 00 = hold.
shifter_data_OutBUS  out  DATAWIDTH  to shifter data input; captured copy of data_in.
busy_out  out  1  high in any state except IDLE.
done_out  out  1  one-cycle pulse when a sequence completes normally.
aborted_out  out  1  one-cycle pulse when a sequence ends via abort.

Behaviour:
- Reset: SC_RegSHIFTER_RESET_InHigh asynchronous, active-high; clock SC_RegSHIFTER_CLOCK_50. Reset forces state IDLE immediately, mid-operation included.
- Reset values: shifter_clear_InLow=1, shifter_load_InLow=1, shiftselection=00, data bus=0, remaining-count=0, busy/done/aborted=0.
- The shifter shares the same reset line, so both blocks return to a consistent zero state together.
- All outputs decode from registered state and registered counters only; no combinational input-to-output paths.
- States and transitions:
  - IDLE: clear_req_in=1 -> CLEAR. Else req_in=1 -> capture data_in, dir_in and count_in, then go to LOAD. clear_req_in wins if both are high.
  - CLEAR: shifter_clear_InLow=0 for exactly 1 cycle -> DONE.
  - LOAD: shifter_load_InLow=0 for exactly 1 cycle. If captured count=0 -> DONE, else -> SHIFT.
  - SHIFT: shiftselection = 01 (dir=0) or 10 (dir=1) every cycle; remaining-count decrements each cycle. Transition to DONE on the cycle remaining-count reaches 1. abort_in=1 in SHIFT -> ABORT immediately, with shiftselection=00 in the ABORT cycle; the shift issued in the abort-sampling cycle still takes effect.
  - DONE: done_out=1 for 1 cycle, controls idle -> IDLE.
  - ABORT: aborted_out=1 for 1 cycle -> IDLE.
- Latency: req sampled at edge t -> LOAD during cycle t+1 -> shifter holds data after edge t+2 -> N SHIFT cycles -> done_out high in cycle t+2+N -> IDLE at t+3+N. Total busy time = N+2 cycles.
- Ignored inputs: req_in and clear_req_in are ignored while busy (no queuing). abort_in is ignored outside SHIFT.
- Mutual exclusion: at most one of clear, load or a non-00 shiftselection is active in any cycle.
- Shift semantics are those of the shifter (logical shift, zero fill). N >= DATAWIDTH yields 0.

Optional Feature:
REGSHIFTER_SEQ_STEP_EN:
- Defined: adds input step_in (1 bit). In SHIFT, a shift is issued and remaining-count decremented only in cycles where step_in=1; other cycles hold shiftselection=00 and the FSM stays in SHIFT. abort_in remains effective.
- Undefined: port absent; one shift every SHIFT cycle as above.

Decomposition:
- Shared package regshifter_pkg holds:
  - state encoding constants: IDLE, CLEAR, LOAD, SHIFT, DONE, ABORT as 3-bit localparams;
  - shift-select codes: SEL_HOLD=00, SEL_LEFT=01, SEL_RIGHT=10.
  The same package is used by SC_RegSHIFTER integration and the testbench.
- One sub-module is natural: regshifter_seq_counter (loadable down-counter with zero/one flags, enable input for step mode).
- FSM and output decode remain in the top.

Test Plan:
- data_in=8'h81, dir=0, count=1, req pulse -> load low 1 cycle, shiftsel=01 for 1 cycle, shifter reads 8'h02, done_out at cycle t+3, busy high 3 cycles.
- data_in=8'hF0, dir=1, count=4 -> 4 cycles of shiftsel=10, shifter ends 8'h0F, done_out at cycle t+6.
- count=0, data_in=8'h5A -> LOAD then DONE, no shift issued, shifter=8'h5A, busy 2 cycles.
- req_in and clear_req_in asserted together in IDLE -> clear low 1 cycle, no load, shifter=0, done_out pulses; second req during busy is ignored.
- data_in=8'hFF, dir=0, count=8, abort_in asserted in the 3rd SHIFT cycle -> 3 shifts applied, shifter=8'hF8, aborted_out pulses, done_out stays 0.
- Reset asserted mid-SHIFT (count=6, after 2 shifts) -> all outputs return to reset values asynchronously, shifter=0, FSM in IDLE; a subsequent req runs a normal sequence.
